// File: rtl/fight_referee.sv
// Turn sequencer and damage resolver for the two-player fighting game: collects one action
// per player per turn, resolves both at once, owns both health counters and declares the result.
module fight_referee #(
  parameter int ACTION_TIMEOUT = 15,
  parameter int MAX_TURNS      = 8,
  parameter int TURN_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        p1_action,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [2:0]        p2_action,
  input  logic              p2_valid,
  output logic              p2_ready,
  output logic [1:0]        p1_health,
  output logic [1:0]        p2_health,
  output logic              turn_done,
  output logic [TURN_W-1:0] turn_count,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int                TO_W      = $clog2(ACTION_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACTION_TIMEOUT - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(MAX_TURNS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESOLVE, S_OVER} state_t;
  typedef enum logic [2:0] {
    A_KICK  = 3'b000,
    A_PUNCH = 3'b001,
    A_WAIT  = 3'b010,
    A_JUMP  = 3'b011,
    A_LEFT  = 3'b100,
    A_RIGHT = 3'b101
  } action_t;

  // Codes 110/111 fold to wait so the resolver only ever sees legal actions.
  function automatic action_t norm(input logic [2:0] a);
    return (a[2:1] == 2'b11) ? A_WAIT : action_t'(a);
  endfunction

  function automatic logic [1:0] damage(input action_t atk, input action_t tgt);
    logic [1:0] d;
    d = 2'd0;
    case (atk)
      A_KICK:  d = (tgt == A_JUMP) ? 2'd0 : ((tgt == A_WAIT) ? 2'd1 : 2'd2);
      A_PUNCH: d = (tgt == A_WAIT) ? 2'd0 : 2'd1;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] sat_sub(input logic [1:0] hp, input logic [1:0] dmg);
    return (hp > dmg) ? (hp - dmg) : 2'd0;
  endfunction

  state_t            r_state, w_next;
  action_t           r_p1_act, r_p2_act, w_p1_eff, w_p2_eff;
  logic              r_p1_lat, r_p2_lat, r_restart, r_turn_done;
  logic [TO_W-1:0]   r_timeout;
  logic [1:0]        r_p1_hp, r_p2_hp, r_winner;
  logic [1:0]        w_p1_new_hp, w_p2_new_hp, w_winner;
  logic [TURN_W-1:0] r_turns, w_turns_next;
  logic              w_p1_take, w_p2_take, w_round_end;

  assign p1_ready   = (r_state == S_COLLECT) && !r_p1_lat;
  assign p2_ready   = (r_state == S_COLLECT) && !r_p2_lat;
  assign w_p1_take  = p1_valid && p1_ready;
  assign w_p2_take  = p2_valid && p2_ready;

  // A player still unlatched at RESOLVE can only be there by timeout, so it plays wait.
  assign w_p1_eff     = r_p1_lat ? r_p1_act : A_WAIT;
  assign w_p2_eff     = r_p2_lat ? r_p2_act : A_WAIT;
  assign w_p1_new_hp  = sat_sub(r_p1_hp, damage(w_p2_eff, w_p1_eff));
  assign w_p2_new_hp  = sat_sub(r_p2_hp, damage(w_p1_eff, w_p2_eff));
  assign w_turns_next = r_turns + 1'b1;
  assign w_round_end  = (w_p1_new_hp == 2'd0) || (w_p2_new_hp == 2'd0) ||
                        (w_turns_next == TURN_LAST);
  // Knockouts and turn-limit decisions both reduce to "higher health wins, tie is a draw".
  assign w_winner     = (w_p1_new_hp > w_p2_new_hp) ? 2'b01 :
                        (w_p2_new_hp > w_p1_new_hp) ? 2'b10 : 2'b11;

  assign p1_health  = r_p1_hp;
  assign p2_health  = r_p2_hp;
  assign turn_done  = r_turn_done;
  assign turn_count = r_turns;
  assign game_over  = (r_state == S_OVER);
  assign winner     = r_winner;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start || r_restart) w_next = S_COLLECT;
      S_COLLECT: if (((r_p1_lat || w_p1_take) && (r_p2_lat || w_p2_take)) ||
                     (r_timeout == TO_LAST)) w_next = S_RESOLVE;
      S_RESOLVE: w_next = w_round_end ? S_OVER : S_COLLECT;
      S_OVER:    if (start) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_p1_hp     <= 2'd3;
      r_p2_hp     <= 2'd3;
      r_turns     <= '0;
      r_turn_done <= 1'b0;
      r_winner    <= 2'b00;
      r_timeout   <= '0;
      r_p1_lat    <= 1'b0;
      r_p2_lat    <= 1'b0;
      r_p1_act    <= A_KICK;
      r_p2_act    <= A_KICK;
      r_restart   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_turn_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_restart <= 1'b0;
          if (start || r_restart) begin
            r_p1_hp   <= 2'd3;
            r_p2_hp   <= 2'd3;
            r_turns   <= '0;
            r_winner  <= 2'b00;
            r_timeout <= '0;
          end
        end
        S_COLLECT: begin
          r_timeout <= r_timeout + 1'b1;
          if (w_p1_take) begin
            r_p1_lat <= 1'b1;
            r_p1_act <= norm(p1_action);
          end
          if (w_p2_take) begin
            r_p2_lat <= 1'b1;
            r_p2_act <= norm(p2_action);
          end
        end
        S_RESOLVE: begin
          r_p1_hp     <= w_p1_new_hp;
          r_p2_hp     <= w_p2_new_hp;
          r_turns     <= w_turns_next;
          r_turn_done <= 1'b1;
          r_p1_lat    <= 1'b0;
          r_p2_lat    <= 1'b0;
          r_p1_act    <= A_KICK;
          r_p2_act    <= A_KICK;
          r_timeout   <= '0;
          if (w_round_end) r_winner <= w_winner;
        end
        S_OVER: begin
          if (start) begin
            r_p1_hp   <= 2'd3;
            r_p2_hp   <= 2'd3;
            r_turns   <= '0;
            r_winner  <= 2'b00;
            r_restart <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fight_referee.sv
// Self-checking bench for fight_referee: a turn-level reference model built from the game
// rules is compared with the DUT every cycle, plus literal expectations for directed turns.
module tb_fight_referee;

  localparam int ACTION_TIMEOUT = 15;
  localparam int MAX_TURNS      = 8;
  localparam int TURN_W         = 4;

  localparam logic [2:0] KICK  = 3'b000;
  localparam logic [2:0] PUNCH = 3'b001;
  localparam logic [2:0] WAITA = 3'b010;
  localparam logic [2:0] JUMP  = 3'b011;
  localparam logic [2:0] LEFT  = 3'b100;
  localparam logic [2:0] RIGHT = 3'b101;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        p1_action = '0;
  logic              p1_valid = 1'b0;
  logic              p1_ready;
  logic [2:0]        p2_action = '0;
  logic              p2_valid = 1'b0;
  logic              p2_ready;
  logic [1:0]        p1_health, p2_health;
  logic              turn_done;
  logic [TURN_W-1:0] turn_count;
  logic              game_over;
  logic [1:0]        winner;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  fight_referee #(
    .ACTION_TIMEOUT(ACTION_TIMEOUT),
    .MAX_TURNS     (MAX_TURNS),
    .TURN_W        (TURN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p1_action (p1_action),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p2_action (p2_action),
    .p2_valid  (p2_valid),
    .p2_ready  (p2_ready),
    .p1_health (p1_health),
    .p2_health (p2_health),
    .turn_done (turn_done),
    .turn_count(turn_count),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (turn-level, rule-driven) ----------------
  int         dmg [8][8];   // dmg[attacker][target]
  int         m_hp1, m_hp2, m_turns, m_win, m_cnt;
  bit         m_collect, m_resolve, m_over, m_auto, m_have1, m_have2, m_done;
  logic [2:0] m_a1, m_a2;

  function automatic bit is_wait(input int c);
    return (c == 2) || (c >= 6);
  endfunction

  task automatic m_clear();
    m_hp1 = 3; m_hp2 = 3; m_turns = 0; m_win = 0; m_cnt = 0;
    m_collect = 0; m_resolve = 0; m_over = 0; m_auto = 0;
    m_have1 = 0; m_have2 = 0; m_done = 0; m_a1 = '0; m_a2 = '0;
  endtask

  task automatic m_new_round();
    m_hp1 = 3; m_hp2 = 3; m_turns = 0; m_win = 0;
  endtask

  task automatic m_step();
    int d1, d2;
    m_done = 0;
    if (m_resolve) begin
      d1 = dmg[m_a2][m_a1];
      d2 = dmg[m_a1][m_a2];
      m_hp1 = (m_hp1 > d1) ? m_hp1 - d1 : 0;
      m_hp2 = (m_hp2 > d2) ? m_hp2 - d2 : 0;
      m_turns++;
      m_done = 1; m_resolve = 0; m_have1 = 0; m_have2 = 0;
      if (m_hp1 == 0 || m_hp2 == 0 || m_turns == MAX_TURNS) begin
        m_over = 1;
        m_win  = (m_hp1 > m_hp2) ? 1 : ((m_hp2 > m_hp1) ? 2 : 3);
      end else begin
        m_collect = 1; m_cnt = 0;
      end
    end else if (m_collect) begin
      if (!m_have1 && p1_valid) begin m_have1 = 1; m_a1 = p1_action; end
      if (!m_have2 && p2_valid) begin m_have2 = 1; m_a2 = p2_action; end
      m_cnt++;
      if ((m_have1 && m_have2) || m_cnt == ACTION_TIMEOUT) begin
        if (!m_have1) m_a1 = WAITA;
        if (!m_have2) m_a2 = WAITA;
        m_collect = 0; m_resolve = 1;
      end
    end else if (m_over) begin
      if (start) begin m_over = 0; m_auto = 1; m_new_round(); end
    end else if (start || m_auto) begin
      m_auto = 0; m_new_round();
      m_collect = 1; m_cnt = 0; m_have1 = 0; m_have2 = 0;
    end
  endtask

  initial begin
    for (int a = 0; a < 8; a++)
      for (int t = 0; t < 8; t++)
        if (a == 0)      dmg[a][t] = (t == 3) ? 0 : (is_wait(t) ? 1 : 2);
        else if (a == 1) dmg[a][t] = is_wait(t) ? 0 : 1;
        else             dmg[a][t] = 0;
    m_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_clear();
      else     m_step();
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("p1_health",  p1_health,  m_hp1);
      check("p2_health",  p2_health,  m_hp2);
      check("turn_count", turn_count, m_turns);
      check("turn_done",  turn_done,  m_done);
      check("game_over",  game_over,  m_over);
      check("winner",     winner,     m_win);
      check("p1_ready",   p1_ready,   m_collect && !m_have1);
      check("p2_ready",   p2_ready,   m_collect && !m_have2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk); #3;
    rst = 1'b1; start = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    #1;
    check("rst_p1_health", p1_health, 3);
    check("rst_p2_health", p2_health, 3);
    check("rst_turn_count", turn_count, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_ready", {p1_ready, p2_ready}, 0);
    check("rst_turn_done", turn_done, 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
  endtask

  // Offer one action per player after dN cycles (dN < 0: stay silent); after a player's
  // handshake its valid keeps toggling with junk, which the referee must ignore.
  task automatic do_turn(input logic [2:0] a1, input logic [2:0] a2, input int d1, input int d2);
    bit got1, got2, seen;
    got1 = 0; got2 = 0; seen = 0;
    for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
      @(negedge clk); #1;
      if (turn_done) begin
        seen = 1;
        p1_valid = 1'b0; p2_valid = 1'b0;
      end else begin
        p1_valid  = got1 ? 1'($urandom_range(0, 1)) : (d1 >= 0 && cyc >= d1);
        p1_action = got1 ? 3'($urandom_range(0, 7)) : a1;
        p2_valid  = got2 ? 1'($urandom_range(0, 1)) : (d2 >= 0 && cyc >= d2);
        p2_action = got2 ? 3'($urandom_range(0, 7)) : a2;
        if (p1_valid && p1_ready) got1 = 1;
        if (p2_valid && p2_ready) got2 = 1;
      end
    end
    check("turn_done_seen", seen, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    do_reset();
    cmp_en = 1'b1;

    // Kick vs wait: p2 loses one point, single turn_done pulse.
    pulse_start();
    do_turn(KICK, WAITA, 0, 0);
    check("t1_p2_health", p2_health, 2);
    check("t1_p1_health", p1_health, 3);
    check("t1_turn_count", turn_count, 1);
    @(negedge clk); #1;
    check("t1_turn_done_pulse", turn_done, 0);

    // Jump dodges a kick but not a punch.
    do_reset();
    pulse_start();
    do_turn(KICK, JUMP, 0, 0);
    check("t2_p2_health_a", p2_health, 3);
    do_turn(PUNCH, JUMP, 1, 0);
    check("t2_p2_health_b", p2_health, 2);
    check("t2_p1_health", p1_health, 3);

    // Mutual kicks twice: health saturates at zero, double knockout.
    do_reset();
    pulse_start();
    do_turn(KICK, KICK, 0, 0);
    check("t3_health_a", {p1_health, p2_health}, 4'b0101);
    do_turn(KICK, KICK, 0, 3);
    check("t3_health_b", {p1_health, p2_health}, 4'b0000);
    check("t3_game_over", game_over, 1);
    check("t3_winner", winner, 3);

    // Restart from OVER, then p2 silent until timeout: punch meets wait.
    pulse_start();
    check("t4_reload_health", {p1_health, p2_health}, 4'b1111);
    check("t4_reload_over", game_over, 0);
    do_turn(PUNCH, KICK, 0, -1);
    check("t4_p2_health", p2_health, 3);
    check("t4_turn_count", turn_count, 1);

    // Eight turns of movement only: decided on equal health.
    do_reset();
    pulse_start();
    for (int i = 0; i < MAX_TURNS; i++) begin
      if (i == MAX_TURNS - 1) check("t5_not_over_early", game_over, 0);
      do_turn(LEFT, RIGHT, i % 3, (i + 1) % 3);
    end
    check("t5_game_over", game_over, 1);
    check("t5_winner", winner, 3);
    check("t5_turn_count", turn_count, MAX_TURNS);
    pulse_start();
    check("t5_reload_turns", turn_count, 0);
    @(negedge clk); #1;
    check("t5_collect_ready", {p1_ready, p2_ready}, 2'b11);

    // Reset with p1 already latched: nothing carries over into the next round.
    @(negedge clk); #1; p1_action = KICK; p1_valid = 1'b1;
    @(negedge clk); #1; p1_valid = 1'b0;
    check("t6_latched_ready", {p1_ready, p2_ready}, 2'b01);
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t6_no_stale_turn", turn_done, 0);
    end
    check("t6_fresh_ready", p1_ready, 1);
    do_turn(PUNCH, KICK, 0, 2);
    check("t6_p1_health", p1_health, 1);
    check("t6_p2_health", p2_health, 2);

    // Randomised rounds, including illegal codes, late or missing actions.
    for (int r = 0; r < 6; r++) begin
      for (int t = 0; t < 12 && !game_over; t++)
        do_turn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                int'($urandom_range(0, 17)) - 1, int'($urandom_range(0, 17)) - 1);
      check("rand_round_over", game_over, 1);
      pulse_start();
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
